// File: rtl/imem_encoder_loader.sv
// imem_encoder_loader
//   Packs field-level instruction requests (R/I/J) into 32-bit MIPS words and
//   streams them into instruction memory starting at word address 0. Codes the
//   controller cannot decode are rejected. The processor stays frozen
//   (cpu_enable=0) until a program has loaded cleanly.
//   Optional feature macro: IMEM_NOP_PAD_EN -- when defined, the words after the
//   final instruction are filled with NOP (32'h0) up to the last address.
module imem_encoder_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [1:0]            in_kind,
  input  logic [5:0]            in_opfunc,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  cpu_enable,
  output logic [1:0]            err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [1:0] KIND_R = 2'd0;
  localparam logic [1:0] KIND_I = 2'd1;
  localparam logic [1:0] KIND_J = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

`ifdef IMEM_NOP_PAD_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DONE  = 3'd2,
    ST_ERROR = 3'd3,
    ST_PAD   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DONE  = 3'd2,
    ST_ERROR = 3'd3
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]             imem_wdata_q, imem_wdata_d;
  logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
  logic                    cpu_enable_q, cpu_enable_d;
  logic [1:0]              err_q, err_d;

  logic                    code_legal;
  logic [31:0]             encoded;

  // Decide whether the requested kind/code is one the controller can decode.
  always_comb begin
    code_legal = 1'b0;
    case (in_kind)
      KIND_R: begin
        case (in_opfunc)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h08,
          6'h20, 6'h21, 6'h22, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B: code_legal = 1'b1;
          default:                    code_legal = 1'b0;
        endcase
      end
      KIND_I: begin
        case (in_opfunc)
          6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
          6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: code_legal = 1'b1;
          default:                                   code_legal = 1'b0;
        endcase
      end
      KIND_J: begin
        code_legal = (in_opfunc == 6'h02) || (in_opfunc == 6'h03);
      end
      default: code_legal = 1'b0;
    endcase
  end

  // Pack the request fields into a 32-bit instruction word.
  always_comb begin
    encoded = 32'h0;
    case (in_kind)
      KIND_R:  encoded = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_opfunc};
      KIND_I:  encoded = {in_opfunc, in_rs, in_rt, in_imm};
      KIND_J:  encoded = {in_opfunc, in_target};
      default: encoded = 32'h0;
    endcase
  end

  // Next-state and registered-output logic; start overrides everything and
  // never coincides with an accept because in_ready is forced low.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    cpu_enable_d = 1'b0;
    err_d        = err_q;
    in_ready     = 1'b0;

    if (start) begin
      state_d      = ST_LOAD;
      ptr_d        = '0;
      word_count_d = '0;
      err_d        = ERR_NONE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (!code_legal) begin
              err_d   = ERR_ILLEGAL;
              state_d = ST_ERROR;
            end else begin
              imem_we_d    = 1'b1;
              imem_addr_d  = ptr_q;
              imem_wdata_d = encoded;
              word_count_d = word_count_q + CNT_ONE;
              ptr_d        = ptr_q + PTR_ONE;
              if (in_last) begin
`ifdef IMEM_NOP_PAD_EN
                state_d = (ptr_q == LAST_ADDR) ? ST_DONE : ST_PAD;
`else
                state_d = ST_DONE;
`endif
              end else if (ptr_q == LAST_ADDR) begin
                // Memory full without a final instruction: keep the word, flag it.
                err_d   = ERR_OVERFLOW;
                state_d = ST_ERROR;
              end
            end
          end
        end
`ifdef IMEM_NOP_PAD_EN
        ST_PAD: begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ptr_q;
          imem_wdata_d = 32'h0;
          word_count_d = word_count_q + CNT_ONE;
          ptr_d        = ptr_q + PTR_ONE;
          if (ptr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          // One cycle behind entering DONE, i.e. after the final write is out.
          cpu_enable_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h0;
      word_count_q <= '0;
      cpu_enable_q <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      word_count_q <= word_count_d;
      cpu_enable_q <= cpu_enable_d;
      err_q        <= err_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
  assign cpu_enable = cpu_enable_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_encoder_loader.sv
// Testbench for imem_encoder_loader (4-word memory). A behavioural model tracks
// load phase, next address and counters; a per-cycle compare process checks the
// DUT against it, and directed tests pin literal words and statuses.
module tb_imem_encoder_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef IMEM_NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [1:0]    in_kind;
  logic [5:0]    in_opfunc;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          cpu_enable;
  logic [1:0]    err;

  int vectors = 0;
  int miscompares = 0;

  imem_encoder_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_kind(in_kind),
    .in_opfunc(in_opfunc), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .cpu_enable(cpu_enable), .err(err)
  );

  always #5 clk = ~clk;

  // Legal code tables, searched linearly.
  logic [5:0] r_codes [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h20, 6'h21,
                               6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] i_codes [12] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  function automatic bit is_legal(input logic [1:0] k, input logic [5:0] c);
    bit ok = 1'b0;
    if (k == 2'd0) begin
      foreach (r_codes[i]) if (r_codes[i] == c) ok = 1'b1;
    end else if (k == 2'd1) begin
      foreach (i_codes[i]) if (i_codes[i] == c) ok = 1'b1;
    end else if (k == 2'd2) begin
      ok = (c == 6'h02) || (c == 6'h03);
    end
    return ok;
  endfunction

  function automatic logic [31:0] enc(input logic [1:0] k, input logic [5:0] c,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
    if (k == 2'd0) return {6'h00, rs, rt, rd, sh, c};
    if (k == 2'd1) return {c, rs, rt, imm};
    return {c, tgt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 loading, 2 done, 3 error, 4 padding.
  int          m_phase, m_ptr, m_count;
  logic [1:0]  m_err;
  bit          m_we, m_cpu;
  int          m_addr;
  logic [31:0] m_wdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_ptr = 0; m_count = 0; m_err = 2'b00;
      m_we = 0; m_cpu = 0; m_addr = 0; m_wdata = 32'h0;
    end else begin
      int p;
      p = m_phase;
      m_we = 0;
      m_cpu = (p == 2) && !start;
      if (start) begin
        m_phase = 1; m_ptr = 0; m_count = 0; m_err = 2'b00;
      end else if (p == 1 && in_valid) begin
        if (!is_legal(in_kind, in_opfunc)) begin
          m_err = 2'b01; m_phase = 3;
        end else begin
          m_we = 1; m_addr = m_ptr; m_count++;
          m_wdata = enc(in_kind, in_opfunc, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
          if (in_last) m_phase = (PAD_EN && m_ptr != DEPTH - 1) ? 4 : 2;
          else if (m_ptr == DEPTH - 1) begin m_err = 2'b10; m_phase = 3; end
          m_ptr++;
        end
      end else if (p == 4) begin
        m_we = 1; m_addr = m_ptr; m_wdata = 32'h0; m_count++;
        if (m_ptr == DEPTH - 1) m_phase = 2;
        m_ptr++;
      end
    end
  end

  // Captured DUT writes for the literal checks.
  logic [AW-1:0] caddr [$];
  logic [31:0]   cdata [$];

  // Per-cycle comparison, a little after each rising edge.
  always @(posedge clk) begin
    #2;
    chk("we", imem_we, m_we);
    if (m_we) begin
      chk("addr", imem_addr, m_addr);
      chk("wdata", imem_wdata, m_wdata);
    end
    chk("word_count", word_count, m_count);
    chk("cpu_enable", cpu_enable, m_cpu);
    chk("err", err, m_err);
    chk("in_ready", in_ready, (m_phase == 1) && !start);
    if (imem_we) begin
      caddr.push_back(imem_addr);
      cdata.push_back(imem_wdata);
      $display("write @%0d = %h count=%0d", imem_addr, imem_wdata, word_count);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    caddr.delete(); cdata.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] k, input logic [5:0] c, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_kind = k; in_opfunc = c; in_rs = rs; in_rt = rt;
    in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
    $display("send kind=%0d code=%h last=%0b", k, c, last);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = '0; in_opfunc = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_we", imem_we, 0);
    chk("rst_cpu", cpu_enable, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_wdata", imem_wdata, 0);
    reset_n = 1'b1;
    idle(1);

    // I + R program
    pulse_start();
    send(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
    send(2'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    idle(6);
    chk("t2_addr0", caddr[0], 0);
    chk("t2_word0", cdata[0], 32'h20220005);
    chk("t2_addr1", caddr[1], 1);
    chk("t2_word1", cdata[1], 32'h00221820);
    chk("t2_wc", word_count, PAD_EN ? 4 : 2);
    chk("t2_cpu", cpu_enable, 1);

    // J single-instruction program
    pulse_start();
    send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1);
    idle(6);
    chk("t3_word0", cdata[0], 32'h08000010);
    chk("t3_cpu", cpu_enable, 1);
    chk("t3_ready", in_ready, 0);

    // Illegal R function, then recover with start
    pulse_start();
    send(2'd0, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
    idle(2);
    chk("t4_err", err, 2'b01);
    chk("t4_cpu", cpu_enable, 0);
    chk("t4_nwrites", caddr.size(), 0);
    pulse_start();
    #1;
    chk("t4_err_clr", err, 2'b00);
    chk("t4_ready", in_ready, 1);

    // Overflow: four words without in_last
    send(2'd1, 6'h0D, 5'd3, 5'd4, 5'd0, 5'd0, 16'hBEEF, 26'h0, 1'b0);
    send(2'd0, 6'h00, 5'd0, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b0);
    send(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h1234567, 1'b0);
    send(2'd1, 6'h23, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b0);
    idle(3);
    chk("t5_err", err, 2'b10);
    chk("t5_cpu", cpu_enable, 0);
    chk("t5_nwrites", caddr.size(), 4);
    chk("t5_addr3", caddr[3], 3);
    chk("t5_word3", cdata[3], 32'h8D09FFFC);

    // Restart mid-load, then two words + in_last
    pulse_start();
    send(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b0);
    idle(0);
    chk("t6_first", cdata[0], 32'h0FFFFFFF);
    pulse_start();
    send(2'd0, 6'h21, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
    send(2'd1, 6'h0F, 5'd0, 5'd7, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
    idle(6);
    chk("t6_addr0", caddr[0], 0);
    chk("t6_word0", cdata[0], 32'h00853021);
    chk("t6_word1", cdata[1], 32'h3C071234);
    chk("t6_nwrites", caddr.size(), PAD_EN ? 4 : 2);
    if (PAD_EN) begin
      chk("t6_pad_addr3", caddr[3], 3);
      chk("t6_pad_word3", cdata[3], 32'h0);
    end
    chk("t6_wc", word_count, PAD_EN ? 4 : 2);
    chk("t6_cpu", cpu_enable, 1);

    // Reset asserted in the middle of a load while a write is on the bus
    pulse_start();
    send(2'd1, 6'h09, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0, 1'b0);
    send(2'd1, 6'h09, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0002, 26'h0, 1'b0);
    chk("t1_we_before", imem_we, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_we", imem_we, 0);
    chk("t1_cpu", cpu_enable, 0);
    chk("t1_ready", in_ready, 0);
    chk("t1_err", err, 0);
    chk("t1_wc", word_count, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
